c_encoder_3_pending: RTL and testbench

Sequential 8-to-3 request encoder and the inverse of the 3-to-8 select decoder. Captures pulses on eight individual request lines into a sticky pending register and presents the index of the winning pending line as a 3-bit select with valid. The consumer retires that line with an ack. Used where decoded one-hot strobes (interrupt/event lines, unit-done signals) must be funnelled back to a single 3-bit index for the control path.

---
 rtl/c_encoder_3_pending_pkg.sv | 19 +
 rtl/c_priority_find.sv | 26 ++
 rtl/c_encoder_3_pending.sv | 98 +++++++++
 tb/tb_c_encoder_3_pending.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/c_encoder_3_pending_pkg.sv
// Shared constants and helpers for the 8-to-3 pending request encoder.
package c_encoder_pkg;

    localparam int N_LINES = 8;
    localparam int SEL_W   = 3;
    localparam int CNT_W   = 4;

    localparam logic [SEL_W-1:0] LAST_RESET = 3'd7;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_LINES-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < N_LINES; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/c_priority_find.sv
// Combinational find-first-set over the request vector, searching upward from
// a start index and wrapping from line 7 back to line 0.
module c_priority_find
    import c_encoder_pkg::*;
(
    input  logic [N_LINES-1:0] req,
    input  logic [SEL_W-1:0]   start,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);

    logic [SEL_W-1:0] pos_s;

    // Walk the eight positions from start; the first set bit is latched into idx.
    always_comb begin
        idx   = 3'd0;
        found = 1'b0;
        pos_s = 3'd0;
        for (int i = 0; i < N_LINES; i++) begin
            pos_s = start + 3'(i);
            idx   = (!found && req[pos_s]) ? pos_s : idx;
            found = found | req[pos_s];
        end
    end

endmodule

// File: rtl/c_encoder_3_pending.sv
// Sequential 8-to-3 request encoder with sticky pending bits and ack retire.
// Define ROUND_ROBIN_EN to rotate priority after each accepted line.
module c_encoder_3_pending
    import c_encoder_pkg::*;
#(
    parameter bit LOST_STICKY = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in0,
    input  logic                in1,
    input  logic                in2,
    input  logic                in3,
    input  logic                in4,
    input  logic                in5,
    input  logic                in6,
    input  logic                in7,
    input  logic                dis,
    input  logic                ack,
    output logic [SEL_W-1:0]    sel,
    output logic                valid,
    output logic [N_LINES-1:0]  pending,
    output logic [CNT_W-1:0]    pending_cnt,
    output logic                lost
);

    logic [N_LINES-1:0] req_s;
    logic [N_LINES-1:0] pending_r;
    logic [N_LINES-1:0] clr_s;
    logic [N_LINES-1:0] pending_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               lost_r;
    logic               lost_hit_s;
    logic               accept_s;
    logic [SEL_W-1:0]   start_s;
    logic [SEL_W-1:0]   win_idx_s;
    logic               found_s;

    assign req_s = {in7, in6, in5, in4, in3, in2, in1, in0};

`ifdef ROUND_ROBIN_EN
    logic [SEL_W-1:0] last_r;

    assign start_s = last_r + 3'd1;

    // Remember the most recently accepted line so the search begins just past it.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= LAST_RESET;
        end else if (accept_s) begin
            last_r <= win_idx_s;
        end else begin
            last_r <= last_r;
        end
    end
`else
    assign start_s = 3'd0;
`endif

    c_priority_find u_find (
        .req   (pending_r),
        .start (start_s),
        .idx   (win_idx_s),
        .found (found_s)
    );

    // Retire mask and next-state: a new request on the retired line re-sets it.
    always_comb begin
        valid          = found_s && !dis;
        sel            = valid ? win_idx_s : 3'd0;
        accept_s       = ack && valid;
        clr_s          = accept_s ? (8'h01 << win_idx_s) : 8'h00;
        pending_next_s = req_s | (pending_r & ~clr_s);
        lost_hit_s     = |(req_s & pending_r & ~clr_s);
    end

    // Pending bits, their popcount and the dropped-request flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= 8'h00;
            cnt_r     <= 4'd0;
            lost_r    <= 1'b0;
        end else begin
            pending_r <= pending_next_s;
            cnt_r     <= popcount(pending_next_s);
            if (LOST_STICKY) begin
                lost_r <= lost_r | lost_hit_s;
            end else begin
                lost_r <= lost_hit_s;
            end
        end
    end

    assign pending     = pending_r;
    assign pending_cnt = cnt_r;
    assign lost        = lost_r;

endmodule

// File: tb/tb_c_encoder_3_pending.sv
// Randomised and directed bench for c_encoder_3_pending; two instances cover
// sticky and pulsed lost behaviour against a behavioural model.
module tb_c_encoder_3_pending;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_v = 8'h00;
    logic       dis = 1'b0;
    logic       ack = 1'b0;

    logic [2:0] sel_a, sel_b;
    logic       valid_a, valid_b;
    logic [7:0] pend_a, pend_b;
    logic [3:0] cnt_a, cnt_b;
    logic       lost_a, lost_b;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    bit [7:0] m_pend = 8'h00;
    int       m_last = 7;
    bit       m_lost_s = 1'b0;
    bit       m_lost_p = 1'b0;

    always #5 clk = ~clk;

    c_encoder_3_pending #(.LOST_STICKY(1'b1)) dut_s (
        .clk(clk), .rst(rst),
        .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]),
        .in4(in_v[4]), .in5(in_v[5]), .in6(in_v[6]), .in7(in_v[7]),
        .dis(dis), .ack(ack),
        .sel(sel_a), .valid(valid_a), .pending(pend_a),
        .pending_cnt(cnt_a), .lost(lost_a)
    );

    c_encoder_3_pending #(.LOST_STICKY(1'b0)) dut_p (
        .clk(clk), .rst(rst),
        .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]),
        .in4(in_v[4]), .in5(in_v[5]), .in6(in_v[6]), .in7(in_v[7]),
        .dis(dis), .ack(ack),
        .sel(sel_b), .valid(valid_b), .pending(pend_b),
        .pending_cnt(cnt_b), .lost(lost_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_winner();
        int start;
`ifdef ROUND_ROBIN_EN
        start = (m_last + 1) % 8;
`else
        start = 0;
`endif
        for (int i = 0; i < 8; i++) begin
            if (m_pend[(start + i) % 8]) return (start + i) % 8;
        end
        return 0;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int k = 0; k < 8; k++) c += int'(m_pend[k]);
        return c;
    endfunction

    // One clock: apply inputs, check combinational outputs, step model, check state.
    task automatic cycle(input logic [7:0] i, input logic a, input logic d, input logic r);
        bit       m_valid, m_acc, any_hit;
        int       w;
        bit [7:0] nxt;
        in_v = i; ack = a; dis = d; rst = r;
        #1;
        m_valid = (m_pend != 8'h00) && !d;
        w       = m_valid ? m_winner() : 0;
        chk("valid_s", int'(valid_a), int'(m_valid));
        chk("sel_s",   int'(sel_a),   w);
        chk("valid_p", int'(valid_b), int'(m_valid));
        chk("sel_p",   int'(sel_b),   w);
        @(posedge clk);
        if (r) begin
            m_pend = 8'h00; m_last = 7; m_lost_s = 1'b0; m_lost_p = 1'b0;
        end else begin
            m_acc   = a && m_valid;
            any_hit = 1'b0;
            for (int k = 0; k < 8; k++) begin
                bit retire;
                retire = m_acc && (w == k);
                if (i[k] && m_pend[k] && !retire) any_hit = 1'b1;
                nxt[k] = i[k] || (m_pend[k] && !retire);
            end
            m_pend   = nxt;
            m_lost_s = m_lost_s || any_hit;
            m_lost_p = any_hit;
            if (m_acc) m_last = w;
        end
        #1;
        chk("pending_s", int'(pend_a), int'(m_pend));
        chk("pending_p", int'(pend_b), int'(m_pend));
        chk("cnt_s",     int'(cnt_a),  m_count());
        chk("cnt_p",     int'(cnt_b),  m_count());
        chk("lost_s",    int'(lost_a), int'(m_lost_s));
        chk("lost_p",    int'(lost_b), int'(m_lost_p));
    endtask

    initial begin
        int exp_sel[3];
        int exp_cnt[4];
        exp_sel = '{2, 5, 7};
        exp_cnt = '{3, 2, 1, 0};

        @(posedge clk); #1;

        // reset with request and ack active
        cycle(8'h08, 1'b1, 1'b0, 1'b1);
        cycle(8'h08, 1'b1, 1'b0, 1'b1);
        chk("rst_pending", int'(pend_a), 0);
        chk("rst_valid",   int'(valid_a), 0);
        chk("rst_sel",     int'(sel_a), 0);
        chk("rst_cnt",     int'(cnt_a), 0);
        chk("rst_lost",    int'(lost_a), 0);

        // simultaneous capture, drained by back-to-back acks
        cycle(8'hA4, 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            chk("cap_sel", int'(sel_a), exp_sel[j]);
            chk("cap_cnt", int'(cnt_a), exp_cnt[j]);
            cycle(8'h00, 1'b1, 1'b0, 1'b0);
        end
        chk("cap_cnt_end", int'(cnt_a), exp_cnt[3]);
        chk("cap_valid_end", int'(valid_a), 0);

        // set wins over retire on the same line
        cycle(8'h01, 1'b0, 1'b0, 1'b0);
        cycle(8'h01, 1'b1, 1'b0, 1'b0);
        chk("setwin_pending", int'(pend_a), 1);
        chk("setwin_valid",   int'(valid_a), 1);
        chk("setwin_sel",     int'(sel_a), 0);
        chk("setwin_lost",    int'(lost_a), 0);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);

        // lost detection
        cycle(8'h10, 1'b0, 1'b0, 1'b0);
        chk("lost_pre_sel", int'(sel_a), 4);
        cycle(8'h10, 1'b0, 1'b0, 1'b0);
        chk("lost_s_set", int'(lost_a), 1);
        chk("lost_p_set", int'(lost_b), 1);
        for (int j = 0; j < 10; j++) cycle(8'h00, 1'b0, 1'b0, 1'b0);
        chk("lost_s_hold", int'(lost_a), 1);
        chk("lost_p_drop", int'(lost_b), 0);
        cycle(8'h00, 1'b0, 1'b0, 1'b1);

        // disable gating
        cycle(8'h42, 1'b1, 1'b1, 1'b0);
        cycle(8'h00, 1'b1, 1'b1, 1'b0);
        cycle(8'h00, 1'b1, 1'b1, 1'b0);
        chk("dis_valid",   int'(valid_a), 0);
        chk("dis_sel",     int'(sel_a), 0);
        chk("dis_pending", int'(pend_a), 8'h42);
        chk("dis_cnt",     int'(cnt_a), 2);
        dis = 1'b0; ack = 1'b0;
        #1;
        chk("undis_valid", int'(valid_a), 1);
        chk("undis_sel",   int'(sel_a), 1);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);

        // fairness: accept line 1, then request 0 and 3 together
        cycle(8'h00, 1'b0, 1'b0, 1'b1);
        cycle(8'h02, 1'b0, 1'b0, 1'b0);
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
        cycle(8'h09, 1'b0, 1'b0, 1'b0);
`ifdef ROUND_ROBIN_EN
        chk("rr_first", int'(sel_a), 3);
`else
        chk("rr_first", int'(sel_a), 0);
`endif
        cycle(8'h00, 1'b1, 1'b0, 1'b0);
`ifdef ROUND_ROBIN_EN
        chk("rr_second", int'(sel_a), 0);
`else
        chk("rr_second", int'(sel_a), 3);
`endif
        cycle(8'h00, 1'b1, 1'b0, 1'b0);

        // randomised traffic
        for (int j = 0; j < 400; j++) begin
            logic [7:0] r_in;
            r_in = 8'($urandom) & 8'($urandom) & 8'($urandom);
            cycle(r_in, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 63) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
